stimulus_conditioner: RTL

// - Front-end stage between the raw pads (ui_in / uio_in) and the stimuli bus

---
 rtl/stim_pkg.sv | 35 +++
 rtl/stimulus_conditioner_if.sv | 14 +
 rtl/stim_debounce.sv | 47 ++++
 rtl/stimulus_conditioner.sv | 85 ++++++++
 4 files changed

// File: rtl/stim_pkg.sv
// Shared definitions for the stimulus front-end: channel map, default
// level/event split and the table of mutually exclusive environment channels.
package stim_pkg;

   localparam int STIM_N_CH = 11;

   localparam int STIM_TICKLE = 0;
   localparam int STIM_PLAY   = 1;
   localparam int STIM_TALK   = 2;
   localparam int STIM_CALM   = 3;
   localparam int STIM_FEED   = 4;
   localparam int STIM_COOL   = 5;
   localparam int STIM_HOT    = 6;
   localparam int STIM_QUIET  = 7;
   localparam int STIM_LOUD   = 8;
   localparam int STIM_DARK   = 9;
   localparam int STIM_BRIGHT = 10;

   // 1 = environment level channel, 0 = button event channel
   localparam logic [STIM_N_CH-1:0] STIM_LEVEL_MASK = 11'b111_1110_0000;

   // Partner of each channel in a mutually exclusive pair, -1 when unpaired
   localparam int STIM_CONFLICT_PARTNER [STIM_N_CH] = '{
      -1, -1, -1, -1, -1,
      STIM_HOT, STIM_COOL, STIM_LOUD, STIM_QUIET, STIM_BRIGHT, STIM_DARK
   };

   function automatic int conflict_partner(input int ch);
      if (ch >= 0 && ch < STIM_N_CH && ch != STIM_TICKLE && ch != STIM_PLAY
          && ch != STIM_TALK && ch != STIM_CALM && ch != STIM_FEED)
         return STIM_CONFLICT_PARTNER[ch];
      return -1;
   endfunction

endpackage

// File: rtl/stimulus_conditioner_if.sv
// Bus between the pads/model-step logic and the stimulus conditioner.
interface stimulus_conditioner_if
   import stim_pkg::*;
#(
   parameter int N_CH = STIM_N_CH
);
   logic [N_CH-1:0] raw_in;
   logic            tick;
   logic [N_CH-1:0] stimuli_out;
   logic            overrun;

   modport master (output raw_in, output tick, input stimuli_out, input overrun);
   modport slave  (input raw_in, input tick, output stimuli_out, output overrun);
endinterface

// File: rtl/stim_debounce.sv
// One channel: 2-flop synchroniser, stability counter, debounced level and a
// one-cycle pulse in the first cycle the debounced level reads high.
module stim_debounce #(
   parameter int DEBOUNCE_CYCLES = 256
) (
   input  logic clk,
   input  logic rst_n,
   input  logic raw,
   output logic stable,
   output logic rise
);
   localparam int CW = (DEBOUNCE_CYCLES > 2) ? $clog2(DEBOUNCE_CYCLES) : 1;
   localparam logic [CW-1:0] CNT_MAX = CW'(DEBOUNCE_CYCLES - 1);

   logic          sync1_reg;
   logic          sync2_reg;
   logic          stable_reg;
   logic          rise_reg;
   logic [CW-1:0] cnt_reg;

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         sync1_reg  <= 1'b0;
         sync2_reg  <= 1'b0;
         stable_reg <= 1'b0;
         rise_reg   <= 1'b0;
         cnt_reg    <= '0;
      end else begin
         sync1_reg <= raw;
         sync2_reg <= sync1_reg;
         rise_reg  <= 1'b0;
         if (sync2_reg == stable_reg) begin
            cnt_reg <= '0;
         end else if (cnt_reg == CNT_MAX) begin
            // Counter restarts here, so it can never wrap
            stable_reg <= sync2_reg;
            rise_reg   <= sync2_reg;
            cnt_reg    <= '0;
         end else begin
            cnt_reg <= cnt_reg + 1'b1;
         end
      end
   end

   assign stable = stable_reg;
   assign rise   = rise_reg;
endmodule

// File: rtl/stimulus_conditioner.sv
// Debounces raw pad stimuli and presents them to the model once per model step:
// buttons as single-step events, environment inputs as conflict-free levels.
module stimulus_conditioner
   import stim_pkg::*;
#(
   parameter int              N_CH            = STIM_N_CH,
   parameter int              DEBOUNCE_CYCLES = 256,
   parameter logic [N_CH-1:0] LEVEL_MASK      = N_CH'(STIM_LEVEL_MASK)
) (
   input  logic                  clk,
   input  logic                  rst_n,
   stimulus_conditioner_if.slave bus
);
   logic [N_CH-1:0] stable;
   logic [N_CH-1:0] rise;
   logic [N_CH-1:0] out_reg;
   logic [N_CH-1:0] out_next;
   logic [N_CH-1:0] ovr_term;
   logic            overrun_reg;

   for (genvar gi = 0; gi < N_CH; gi++) begin : g_ch
      stim_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db (
         .clk    (clk),
         .rst_n  (rst_n),
         .raw    (bus.raw_in[gi]),
         .stable (stable[gi]),
         .rise   (rise[gi])
      );

      if (!LEVEL_MASK[gi]) begin : g_event
         logic pending_reg;
         logic ovf_reg;
         logic unused_stable;

         assign unused_stable = stable[gi];

         always_ff @(posedge clk) begin
            if (!rst_n) begin
               pending_reg <= 1'b0;
               ovf_reg     <= 1'b0;
            end else if (bus.tick) begin
               pending_reg <= 1'b0;
               ovf_reg     <= 1'b0;
            end else if (rise[gi]) begin
               pending_reg <= 1'b1;
               ovf_reg     <= ovf_reg | pending_reg;
            end
         end

         // A press landing on the tick cycle itself belongs to this step
         assign out_next[gi] = bus.tick ? (pending_reg | rise[gi]) : out_reg[gi];
         assign ovr_term[gi] = (pending_reg & rise[gi]) | ovf_reg;
      end else begin : g_level
         localparam int PARTNER = conflict_partner(gi);
         logic level_val;
         logic unused_rise;

         assign unused_rise = rise[gi];

         if (PARTNER >= 0 && PARTNER < N_CH) begin : g_pair
            assign level_val = stable[gi] & ~stable[PARTNER];
         end else begin : g_solo
            assign level_val = stable[gi];
         end

         assign out_next[gi] = bus.tick ? level_val : out_reg[gi];
         assign ovr_term[gi] = 1'b0;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         out_reg     <= '0;
         overrun_reg <= 1'b0;
      end else begin
         out_reg <= out_next;
         if (bus.tick) begin
            overrun_reg <= |ovr_term;
         end
      end
   end

   assign bus.stimuli_out = out_reg;
   assign bus.overrun     = overrun_reg;
endmodule
